// File: rtl/demux_1to4_buf_pkg.sv
// Shared constants for the 1-to-4 buffered demultiplexer.
package demux_1to4_buf_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 16;

  localparam logic [SEL_W-1:0] CH0 = 2'd0;
  localparam logic [SEL_W-1:0] CH1 = 2'd1;
  localparam logic [SEL_W-1:0] CH2 = 2'd2;
  localparam logic [SEL_W-1:0] CH3 = 2'd3;
endpackage

// File: rtl/demux_1to4_buf_if.sv
// Producer-side and consumer-side handshake bundle for demux_1to4_buf.
interface demux_1to4_buf_if import demux_1to4_buf_pkg::*; #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]        in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;

  // master = testbench / surrounding logic, slave = the demux itself
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/demux_slot.sv
// One-entry holding slot for a single output channel.
// Optional delivered-word counter under DEMUX_STATS_EN.
module demux_slot import demux_1to4_buf_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             rdy,
  output logic             valid,
  output logic [WIDTH-1:0] data
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);
  logic             r_full;
  logic [WIDTH-1:0] r_data;
  logic             w_drain;

  assign w_drain = r_full & rdy;
  assign valid   = r_full;
  assign data    = r_data;

  // Load wins over drain so a same-cycle refill keeps the slot full (no bubble)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (load) begin
      r_full <= 1'b1;
      r_data <= ld_data;
    end else if (w_drain) begin
      r_full <= 1'b0;
    end
  end

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] r_cnt;
  assign cnt = r_cnt;

  // Count every delivered word; wraps naturally at the counter width
  always_ff @(posedge clk) begin
    if (rst)          r_cnt <= '0;
    else if (w_drain) r_cnt <= r_cnt + 1'b1;
  end
`endif
endmodule

// File: rtl/demux_1to4_buf.sv
// Registered 1-to-4 demux with per-channel one-entry buffering.
// Optional per-channel delivery counters: define DEMUX_STATS_EN.
module demux_1to4_buf import demux_1to4_buf_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  demux_1to4_buf_if.slave bus
`ifdef DEMUX_STATS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] xfer_cnt
`endif
);
  logic [NUM_CH-1:0]            w_full;
  logic [NUM_CH-1:0]            w_load;
  logic [NUM_CH-1:0][WIDTH-1:0] w_data;
  logic                         w_acc;

  // Selected slot can take a word if empty or draining this cycle
  assign bus.in_ready  = ~w_full[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign w_acc         = bus.in_valid & bus.in_ready;
  assign bus.out_valid = w_full;
  assign bus.out_data  = w_data;

`ifdef DEMUX_STATS_EN
  logic [NUM_CH-1:0][CNT_W-1:0] w_cnt;
  assign xfer_cnt = w_cnt;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign w_load[k] = w_acc & (bus.in_sel == SEL_W'(k));

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (w_load[k]),
      .ld_data (bus.in_data),
      .rdy     (bus.out_ready[k]),
      .valid   (w_full[k]),
      .data    (w_data[k])
`ifdef DEMUX_STATS_EN
      ,
      .cnt     (w_cnt[k])
`endif
    );
  end
endmodule
